gate_request_conditioner: RTL and testbench

Front-end stage directly upstream of the parking FSM. It synchronises and debounces the raw entry and exit gate sensors, and captures the exit slot number. It queues pending requests and issues clean single-cycle entry_signal / exit_signal / exit_slot pulses to the FSM. It arbitrates simultaneous requests, holds entries while the lot is full, and spaces issues so that the FSM's is_full output has settled before the next decision.

---
 rtl/parking_pkg.sv | 8 +
 rtl/sensor_debounce.sv | 38 +++
 rtl/gate_request_conditioner.sv | 81 ++++++++
 tb/tb_gate_request_conditioner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// parking_pkg: shared slot width, default timing constants and debouncer state encoding
package parking_pkg;
    localparam int SLOT_W         = 2;
    localparam int DEF_DEBOUNCE   = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_ISSUE_GAP  = 2;
    typedef enum logic {DB_IDLE, DB_ARMED_WAIT} db_state_t;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser and debounce FSM, one strobe per stable high period
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic strobe
);
    logic [1:0] sens_sync;
    logic [3:0] cnt;
    logic       hit;
    logic       last;
    db_state_t  state;
    // IDLE waits for a run of highs, ARMED_WAIT for a run of lows; one counter serves both
    assign hit    = state == DB_IDLE ? sens_sync[1] : !sens_sync[1];
    assign last   = cnt == 4'(DEBOUNCE - 1);
    assign strobe = state == DB_IDLE && hit && last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sens_sync <= '0;
            cnt       <= '0;
            state     <= DB_IDLE;
        end else begin
            sens_sync <= {sens_sync[0], sensor};
            if (!hit) begin
                cnt <= '0;
            end else if (last) begin
                cnt   <= '0;
                state <= state == DB_IDLE ? DB_ARMED_WAIT : DB_IDLE;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/gate_request_conditioner.sv
// gate_request_conditioner: debounces gate sensors, queues exit requests and paces
// single-cycle entry/exit requests to the parking FSM
module gate_request_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE   = DEF_DEBOUNCE,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ISSUE_GAP  = DEF_ISSUE_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry_sensor,
    input  logic              exit_sensor,
    input  logic [SLOT_W-1:0] exit_slot_in,
    input  logic              is_full,
    output logic              entry_signal,
    output logic              exit_signal,
    output logic [SLOT_W-1:0] exit_slot,
    output logic              entry_pending,
    output logic [2:0]        exit_count,
    output logic              exit_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(ISSUE_GAP + 1);

    logic              entry_ev, exit_ev, idle, pop, push, issue_entry, full;
    logic [SLOT_W-1:0] slot_meta, slot_sync;
    logic [SLOT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [GW-1:0]     cooldown;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_entry (
        .clk(clk), .reset(reset), .sensor(entry_sensor), .strobe(entry_ev)
    );
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit (
        .clk(clk), .reset(reset), .sensor(exit_sensor), .strobe(exit_ev)
    );

    // exits win arbitration because they free a spot the pending entry may need
    assign full        = count == CW'(FIFO_DEPTH);
    assign idle        = cooldown == '0;
    assign pop         = idle && count != '0;
    assign issue_entry = idle && count == '0 && entry_pending && !is_full;
    assign push        = exit_ev && (!full || pop);
    assign exit_count  = 3'(count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_meta     <= '0;
            slot_sync     <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            cooldown      <= '0;
            entry_pending <= 1'b0;
            entry_signal  <= 1'b0;
            exit_signal   <= 1'b0;
            exit_slot     <= '0;
            exit_overflow <= 1'b0;
        end else begin
            slot_meta     <= exit_slot_in;
            slot_sync     <= slot_meta;
            rd_ptr        <= rd_ptr + AW'(pop);
            wr_ptr        <= wr_ptr + AW'(push);
            count         <= count + CW'(push) - CW'(pop);
            cooldown      <= (pop || issue_entry) ? GW'(ISSUE_GAP - 1) : cooldown - GW'(!idle);
            entry_pending <= entry_ev || (entry_pending && !issue_entry);
            entry_signal  <= issue_entry;
            exit_signal   <= pop;
            exit_slot     <= pop ? mem[rd_ptr] : '0;
            exit_overflow <= exit_ev && !push;
        end
    end

    // slot storage needs no reset; only written entries are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= slot_sync;
    end
endmodule

// File: tb/tb_gate_request_conditioner.sv
// tb_gate_request_conditioner: scoreboarded checks of debounce, arbitration, pacing, overflow and reset
module tb_gate_request_conditioner;
    localparam int GAP2 = 12;
    typedef struct {bit ex; logic [1:0] slot; int cyc;} ev_t;

    logic clk = 1'b0, reset = 1'b0;
    logic entry_sensor = 1'b0, exit_sensor = 1'b0, is_full = 1'b0;
    logic [1:0] exit_slot_in = '0;
    logic entry_signal, exit_signal, entry_pending, exit_overflow;
    logic [1:0] exit_slot;
    logic [2:0] exit_count;
    logic entry_sensor2 = 1'b0, exit_sensor2 = 1'b0, is_full2 = 1'b0;
    logic [1:0] exit_slot_in2 = '0;
    logic entry_signal2, exit_signal2, entry_pending2, exit_overflow2;
    logic [1:0] exit_slot2;
    logic [2:0] exit_count2;

    int cyc = 0, n_vec = 0, n_err = 0, ovf2 = 0, both = 0, stray = 0;
    ev_t exp_q[$], obs_q[$], obs2_q[$];

    gate_request_conditioner dut (
        .clk(clk), .reset(reset), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .exit_slot_in(exit_slot_in), .is_full(is_full), .entry_signal(entry_signal),
        .exit_signal(exit_signal), .exit_slot(exit_slot), .entry_pending(entry_pending),
        .exit_count(exit_count), .exit_overflow(exit_overflow)
    );

    // second instance with a short debounce and long gap so the queue can actually fill
    gate_request_conditioner #(.DEBOUNCE(1), .FIFO_DEPTH(4), .ISSUE_GAP(GAP2)) dut2 (
        .clk(clk), .reset(reset), .entry_sensor(entry_sensor2), .exit_sensor(exit_sensor2),
        .exit_slot_in(exit_slot_in2), .is_full(is_full2), .entry_signal(entry_signal2),
        .exit_signal(exit_signal2), .exit_slot(exit_slot2), .entry_pending(entry_pending2),
        .exit_count(exit_count2), .exit_overflow(exit_overflow2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (entry_signal)  obs_q.push_back(ev_t'{1'b0, 2'b00, cyc});
            if (exit_signal)   obs_q.push_back(ev_t'{1'b1, exit_slot, cyc});
            if (entry_signal2) obs2_q.push_back(ev_t'{1'b0, 2'b00, cyc});
            if (exit_signal2)  obs2_q.push_back(ev_t'{1'b1, exit_slot2, cyc});
            if (exit_overflow2) ovf2++;
            if ((entry_signal && exit_signal) || (entry_signal2 && exit_signal2)) both++;
            if ((!exit_signal && exit_slot != 2'b00) || (!exit_signal2 && exit_slot2 != 2'b00)) stray++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(3);
        n_vec += 6;
        if (entry_signal !== 1'b0)  begin n_err++; $display("FAIL reset_entry_signal: got %b want 0", entry_signal); end
        if (exit_signal !== 1'b0)   begin n_err++; $display("FAIL reset_exit_signal: got %b want 0", exit_signal); end
        if (exit_slot !== 2'b00)    begin n_err++; $display("FAIL reset_exit_slot: got %b want 00", exit_slot); end
        if (entry_pending !== 1'b0) begin n_err++; $display("FAIL reset_entry_pending: got %b want 0", entry_pending); end
        if (exit_count !== 3'd0)    begin n_err++; $display("FAIL reset_exit_count: got %0d want 0", exit_count); end
        if (exit_overflow !== 1'b0) begin n_err++; $display("FAIL reset_exit_overflow: got %b want 0", exit_overflow); end
        reset = 1'b1;
        tick(3);
    endtask

    task automatic test_entry_latency();
        ev_t e, o;
        int p;
        p = cyc;
        entry_sensor = 1'b1;
        exp_q.push_back(ev_t'{1'b0, 2'b00, p + 7});
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) begin
                n_vec++;
                if (entry_pending !== 1'b1) begin n_err++; $display("FAIL entry_pending_before: got %b want 1", entry_pending); end
            end
            if (i == 7) begin
                n_vec++;
                if (entry_pending !== 1'b0) begin n_err++; $display("FAIL entry_pending_cleared: got %b want 0", entry_pending); end
            end
        end
        entry_sensor = 1'b0;
        tick(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL entry_pulse: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL entry_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch_exit();
        ev_t e, o;
        int p;
        exit_slot_in = 2'b10;
        exit_sensor = 1'b1;
        tick(3);
        exit_sensor = 1'b0;
        tick(10);
        n_vec += 2;
        if (exit_count !== 3'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", exit_count); end
        if (obs_q.size() != 0)   begin n_err++; $display("FAIL glitch_pulse: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
        p = cyc;
        exit_sensor = 1'b1;
        exp_q.push_back(ev_t'{1'b1, 2'b10, p + 7});
        tick(6);
        n_vec++;
        if (exit_count !== 3'd1) begin n_err++; $display("FAIL exit_queued: got %0d want 1", exit_count); end
        exit_sensor = 1'b0;
        tick();
        n_vec++;
        if (exit_count !== 3'd0) begin n_err++; $display("FAIL exit_popped: got %0d want 0", exit_count); end
        tick(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL exit_pulse: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL exit_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        int p;
        p = cyc;
        exit_slot_in = 2'b01;
        entry_sensor = 1'b1;
        exit_sensor = 1'b1;
        exp_q.push_back(ev_t'{1'b1, 2'b01, p + 7});
        exp_q.push_back(ev_t'{1'b0, 2'b00, p + 9});
        tick(6);
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        tick(14);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL simul_pulse: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL simul_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_full_hold();
        ev_t e, o;
        int q;
        is_full = 1'b1;
        entry_sensor = 1'b1;
        tick(6);
        entry_sensor = 1'b0;
        for (int i = 7; i <= 26; i++) begin
            tick();
            n_vec++;
            if (entry_pending !== 1'b1) begin n_err++; $display("FAIL full_pending cyc %0d: got %b want 1", i, entry_pending); end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL full_blocked: got %0d pulses want 0", obs_q.size()); obs_q.delete(); end
        q = cyc;
        is_full = 1'b0;
        exp_q.push_back(ev_t'{1'b0, 2'b00, q + 1});
        tick(4);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() != 0) o = obs_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL full_release: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL full_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_overflow();
        ev_t e, o;
        int p;
        logic [1:0] slots [6] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ovf2 = 0;
        p = cyc;
        // first event is issued at once and starts the long cooldown the rest pile up behind
        exp_q.push_back(ev_t'{1'b1, 2'd3, p + 4});
        for (int k = 0; k < 4; k++) exp_q.push_back(ev_t'{1'b1, 2'(k), p + 4 + GAP2 * (k + 1)});
        for (int i = 0; i < 6; i++) begin
            exit_slot_in2 = slots[i];
            exit_sensor2 = 1'b1;
            tick();
            exit_sensor2 = 1'b0;
            tick();
        end
        n_vec++;
        if (exit_count2 !== 3'd4) begin n_err++; $display("FAIL ovf_count_full: got %0d want 4", exit_count2); end
        tick();
        n_vec += 2;
        if (exit_overflow2 !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", exit_overflow2); end
        if (exit_count2 !== 3'd4)    begin n_err++; $display("FAIL ovf_count_hold: got %0d want 4", exit_count2); end
        tick(50);
        n_vec += 2;
        if (ovf2 !== 1)           begin n_err++; $display("FAIL ovf_once: got %0d pulses want 1", ovf2); end
        if (exit_count2 !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d want 0", exit_count2); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs2_q.size() != 0) o = obs2_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL ovf_pop: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        n_vec++;
        if (obs2_q.size() != 0) begin n_err++; $display("FAIL ovf_extra: got %0d extra pulses want 0", obs2_q.size()); obs2_q.delete(); end
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        int p;
        logic [1:0] slots [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        p = cyc;
        exp_q.push_back(ev_t'{1'b1, 2'd1, p + 4});
        for (int i = 0; i < 4; i++) begin
            exit_slot_in2 = slots[i];
            exit_sensor2 = 1'b1;
            entry_sensor2 = i == 1;
            tick();
            exit_sensor2 = 1'b0;
            entry_sensor2 = 1'b0;
            tick();
        end
        tick(2);
        n_vec += 2;
        if (exit_count2 !== 3'd3)     begin n_err++; $display("FAIL mid_count: got %0d want 3", exit_count2); end
        if (entry_pending2 !== 1'b1)  begin n_err++; $display("FAIL mid_pending: got %b want 1", entry_pending2); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs2_q.size() != 0) o = obs2_q.pop_front(); else o = ev_t'{1'b0, 2'b00, -1};
            if (o.ex !== e.ex || o.slot !== e.slot || o.cyc !== e.cyc) begin
                n_err++;
                $display("FAIL mid_prime: got ex=%0d slot=%0d cyc=%0d want ex=%0d slot=%0d cyc=%0d", o.ex, o.slot, o.cyc, e.ex, e.slot, e.cyc);
            end
        end
        #3 reset = 1'b0;
        #1;
        n_vec += 5;
        if (exit_count2 !== 3'd0)    begin n_err++; $display("FAIL async_count: got %0d want 0", exit_count2); end
        if (entry_pending2 !== 1'b0) begin n_err++; $display("FAIL async_pending: got %b want 0", entry_pending2); end
        if (exit_signal2 !== 1'b0 || entry_signal2 !== 1'b0) begin n_err++; $display("FAIL async_signals: got %b%b want 00", exit_signal2, entry_signal2); end
        if (exit_slot2 !== 2'b00)    begin n_err++; $display("FAIL async_slot: got %b want 00", exit_slot2); end
        if (exit_overflow2 !== 1'b0) begin n_err++; $display("FAIL async_overflow: got %b want 0", exit_overflow2); end
        tick(2);
        reset = 1'b1;
        tick(40);
        n_vec += 3;
        if (obs2_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL post_reset_pulses: got %0d want 0", obs2_q.size() + obs_q.size()); end
        if (exit_count2 !== 3'd0)    begin n_err++; $display("FAIL post_reset_count: got %0d want 0", exit_count2); end
        if (entry_pending2 !== 1'b0) begin n_err++; $display("FAIL post_reset_pending: got %b want 0", entry_pending2); end
    endtask

    task automatic test_issue_rules();
        n_vec += 2;
        if (both != 0)  begin n_err++; $display("FAIL one_hot_issue: got %0d overlapping cycles want 0", both); end
        if (stray != 0) begin n_err++; $display("FAIL idle_slot_zero: got %0d nonzero cycles want 0", stray); end
    endtask

    initial begin
        test_reset();
        test_entry_latency();
        test_glitch_exit();
        test_simultaneous();
        test_full_hold();
        test_overflow();
        test_reset_mid();
        test_issue_rules();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
